debounce_bank: RTL and testbench
================================

DEBOUNCE_BANK -- requirements
Module: debounce_bank

Interface
REQ-001 SHALL have parameter CH, default 4: number of independent switch channels, range 1..32.
REQ-002 SHALL have parameter DB_CYCLES, default 1000000: stable-sample count that qualifies a change, minimum 1.
REQ-003 SHALL have parameter LP_CYCLES, default 50000000: debounced-high duration that qualifies a long press, minimum 1.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port sw, input, CH bits: raw asynchronous switch inputs, bit i is channel i.
REQ-007 SHALL have port db_level, output, CH bits: debounced level per channel.
REQ-008 SHALL have port rise_tick, output, CH bits: one-cycle pulse when db_level[i] rises.
REQ-009 SHALL have port fall_tick, output, CH bits: one-cycle pulse when db_level[i] falls.
REQ-010 SHALL have port long_tick, output, CH bits: one-cycle pulse on long-press qualification.

Function
REQ-011 Each sw[i] SHALL pass through a 2-flop synchronizer; its output sw_s[i] is the only value the FSM sees.
REQ-012 Channels SHALL be fully independent: per channel, one 4-state FSM (ZERO, WAIT1, ONE, WAIT0) and a down-counter of width $clog2(DB_CYCLES+1).
REQ-013 ZERO: if sw_s=1, go to WAIT1 and load the counter with DB_CYCLES-1; otherwise stay.
REQ-014 WAIT1: if sw_s=0, return to ZERO with no tick; else if the counter is 0, go to ONE; else decrement.
REQ-015 ONE: if sw_s=0, go to WAIT0 and load the counter with DB_CYCLES-1; otherwise stay.
REQ-016 WAIT0: if sw_s=1, return to ONE with no tick; else if the counter is 0, go to ZERO; else decrement.
REQ-017 db_level[i] SHALL be registered and equal 1 exactly when the channel is in ONE or WAIT0.
REQ-018 Latency: sw_s high at DB_CYCLES+1 consecutive edges t..t+DB_CYCLES SHALL raise db_level at edge t+DB_CYCLES; the falling direction is symmetric.
REQ-019 rise_tick[i] SHALL be registered and high for exactly the one cycle following the WAIT1-to-ONE edge, coincident with db_level's first high cycle.
REQ-020 fall_tick[i] SHALL be registered and high for exactly the one cycle following the WAIT0-to-ZERO edge.
REQ-021 Any glitch shorter than the qualifying window SHALL produce no change on db_level and no tick.
REQ-022 A DB_CYCLES=1 build SHALL qualify after two consecutive equal samples.
REQ-023 Simultaneous transitions on several channels SHALL each produce their own ticks in the same cycle.

Reset
REQ-024 While reset=1, every channel SHALL be in ZERO with its counters and synchronizer flops at 0.
REQ-025 While reset=1, db_level, rise_tick, fall_tick and long_tick SHALL all be 0.
REQ-026 Reset asserted mid-qualification SHALL abort it with no tick; after release, qualification restarts from sw_s.

Configuration
REQ-027 Macro DEBOUNCE_BANK_LONG_PRESS_EN defined: each channel SHALL add a saturating counter of width $clog2(LP_CYCLES+1), cleared in ZERO and WAIT1 and incremented in ONE and WAIT0.
REQ-028 With the macro defined, long_tick[i] SHALL pulse exactly one cycle when that counter reaches LP_CYCLES; it SHALL fire at most once per press and not re-fire while saturated.
REQ-029 Macro undefined: long_tick SHALL be constant 0, no long-press counters SHALL be synthesized, and all other behaviour SHALL be unchanged.

Verification (CH=4, DB_CYCLES=4, LP_CYCLES=10)
REQ-030 sw[0] 0->1 and held -> db_level[0]=1 and rise_tick[0] pulses 1 cycle, 2+4 cycles after sw_s sampling begins; other channels stay 0.
REQ-031 sw[1] high-pulse 3 cycles wide -> db_level[1] and all ticks stay 0.
REQ-032 sw[2] held high, then low 2 cycles, then high -> db_level[2] stays 1; no fall_tick.
REQ-033 sw=4'b1111 applied at once -> rise_tick=4'b1111 in the same cycle; release at once -> fall_tick=4'b1111 in the same cycle.
REQ-034 reset pulsed while channel 3 is in WAIT1 -> no rise_tick; all outputs 0; after release, the full window is required again.
REQ-035 Macro defined, sw[0] held -> long_tick[0] pulses once, 10 cycles after rise_tick[0]; it never pulses when the macro is undefined.

Source files
------------

// File: rtl/debounce_bank_if.sv
// Switch bank bundle: raw switch inputs toward the debouncer, debounced level and edge/long-press ticks back.
interface debounce_bank_if #(
    parameter int CH = 4
);
    logic [CH-1:0] sw;
    logic [CH-1:0] db_level;
    logic [CH-1:0] rise_tick;
    logic [CH-1:0] fall_tick;
    logic [CH-1:0] long_tick;

    modport master (
        output sw,
        input  db_level, rise_tick, fall_tick, long_tick
    );

    modport slave (
        input  sw,
        output db_level, rise_tick, fall_tick, long_tick
    );
endinterface

// File: rtl/debounce_bank.sv
// Bank of independent switch debouncers: 2-flop synchronizer, 4-state qualify FSM, edge ticks.
// Optional long-press detector enabled by defining DEBOUNCE_BANK_LONG_PRESS_EN.
module debounce_bank #(
    parameter int CH        = 4,
    parameter int DB_CYCLES = 1000000,
    parameter int LP_CYCLES = 50000000
) (
    input  logic            clk,
    input  logic            reset,
    debounce_bank_if.slave  db_if
);
    typedef enum logic [1:0] {ZERO = 2'd0, WAIT1 = 2'd1, ONE = 2'd2, WAIT0 = 2'd3} state_t;

    localparam int              CW      = $clog2(DB_CYCLES + 1);
    localparam logic [CW-1:0]   DB_LOAD = CW'(DB_CYCLES - 1);

    if (CH < 1 || CH > 32) begin : g_bad_ch
        $error("debounce_bank: CH out of range 1..32");
    end
    if (DB_CYCLES < 1) begin : g_bad_db
        $error("debounce_bank: DB_CYCLES must be at least 1");
    end
    if (LP_CYCLES < 1) begin : g_bad_lp
        $error("debounce_bank: LP_CYCLES must be at least 1");
    end

`ifdef DEBOUNCE_BANK_LONG_PRESS_EN
    localparam int              LW     = $clog2(LP_CYCLES + 1);
    localparam logic [LW-1:0]   LP_MAX = LW'(LP_CYCLES);
`endif

    logic [CH-1:0] sync1_q;
    logic [CH-1:0] sync2_q;
    logic [CH-1:0] db_level_s;
    logic [CH-1:0] rise_s;
    logic [CH-1:0] fall_s;
    logic [CH-1:0] long_s;

    // Two-stage synchronizer for the raw asynchronous switch inputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= db_if.sw;
            sync2_q <= sync1_q;
        end
    end

    for (genvar g = 0; g < CH; g++) begin : g_ch
        state_t          state_q;
        logic [CW-1:0]   cnt_q;
        logic            db_q;
        logic            rise_q;
        logic            fall_q;

        // Per-channel qualify FSM; level and ticks are updated on the qualifying edge itself
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                state_q <= ZERO;
                cnt_q   <= '0;
                db_q    <= 1'b0;
                rise_q  <= 1'b0;
                fall_q  <= 1'b0;
            end else begin
                rise_q <= 1'b0;
                fall_q <= 1'b0;
                case (state_q)
                    ZERO: begin
                        if (sync2_q[g]) begin
                            state_q <= WAIT1;
                            cnt_q   <= DB_LOAD;
                        end
                    end
                    WAIT1: begin
                        if (!sync2_q[g]) begin
                            state_q <= ZERO;
                        end else if (cnt_q == '0) begin
                            state_q <= ONE;
                            db_q    <= 1'b1;
                            rise_q  <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q - CW'(1);
                        end
                    end
                    ONE: begin
                        if (!sync2_q[g]) begin
                            state_q <= WAIT0;
                            cnt_q   <= DB_LOAD;
                        end
                    end
                    WAIT0: begin
                        if (sync2_q[g]) begin
                            state_q <= ONE;
                        end else if (cnt_q == '0) begin
                            state_q <= ZERO;
                            db_q    <= 1'b0;
                            fall_q  <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q - CW'(1);
                        end
                    end
                    default: begin
                        state_q <= ZERO;
                        cnt_q   <= '0;
                        db_q    <= 1'b0;
                    end
                endcase
            end
        end

        assign db_level_s[g] = db_q;
        assign rise_s[g]     = rise_q;
        assign fall_s[g]     = fall_q;

`ifdef DEBOUNCE_BANK_LONG_PRESS_EN
        logic [LW-1:0] lp_q;
        logic          long_q;

        // Saturating press-duration counter; the tick fires only on the step into saturation
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                lp_q   <= '0;
                long_q <= 1'b0;
            end else begin
                long_q <= 1'b0;
                if (state_q == ONE || state_q == WAIT0) begin
                    if (lp_q != LP_MAX) begin
                        lp_q   <= lp_q + LW'(1);
                        long_q <= (lp_q == LP_MAX - LW'(1));
                    end
                end else begin
                    lp_q <= '0;
                end
            end
        end

        assign long_s[g] = long_q;
`else
        assign long_s[g] = 1'b0;
`endif
    end

    assign db_if.db_level  = db_level_s;
    assign db_if.rise_tick = rise_s;
    assign db_if.fall_tick = fall_s;
    assign db_if.long_tick = long_s;
endmodule

// File: tb/tb_debounce_bank.sv
// Scoreboard bench for debounce_bank with CH=4, DB_CYCLES=4, LP_CYCLES=10.
module tb_debounce_bank;
    typedef struct packed {
        logic [3:0] lvl;
        logic [3:0] rise;
        logic [3:0] fall;
        logic [3:0] lng;
    } frame_t;

`ifdef DEBOUNCE_BANK_LONG_PRESS_EN
    localparam bit LP_EN = 1'b1;
`else
    localparam bit LP_EN = 1'b0;
`endif

    logic   clk = 1'b0;
    logic   reset = 1'b1;
    int     tests_run = 0;
    int     failed = 0;
    frame_t exp_q[$];

    debounce_bank_if #(.CH(4)) bus ();

    debounce_bank #(.CH(4), .DB_CYCLES(4), .LP_CYCLES(10)) dut (
        .clk   (clk),
        .reset (reset),
        .db_if (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] lp(input logic [3:0] v);
        return LP_EN ? v : 4'b0000;
    endfunction

    task automatic push_n(input int n, input logic [3:0] lvl, input logic [3:0] rise,
                          input logic [3:0] fall, input logic [3:0] lng);
        frame_t f;
        f = '{lvl: lvl, rise: rise, fall: fall, lng: lng};
        for (int i = 0; i < n; i++) exp_q.push_back(f);
    endtask

    function automatic frame_t observe();
        return '{lvl: bus.db_level, rise: bus.rise_tick, fall: bus.fall_tick, lng: bus.long_tick};
    endfunction

    task automatic test_reset();
        frame_t got, exp;
        bus.sw = 4'b1111;
        push_n(8, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        for (int k = 0; k < 8; k++) begin
            if (k == 4) begin
                reset  = 1'b0;
                bus.sw = 4'b0000;
            end
            @(posedge clk);
            @(negedge clk);
            got = observe();
            exp = exp_q.pop_front();
            tests_run++;
            if (got !== exp) begin
                failed++;
                $display("FAIL reset k=%0d got=%h exp=%h", k, got, exp);
            end
        end
    endtask

    task automatic test_rise_fall();
        frame_t got, exp;
        push_n(6, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        push_n(1, 4'b0001, 4'b0001, 4'b0000, 4'b0000);
        push_n(9, 4'b0001, 4'b0000, 4'b0000, 4'b0000);
        push_n(1, 4'b0001, 4'b0000, 4'b0000, lp(4'b0001));
        push_n(9, 4'b0001, 4'b0000, 4'b0000, 4'b0000);
        push_n(1, 4'b0000, 4'b0000, 4'b0001, 4'b0000);
        push_n(1, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        for (int k = 0; k < 28; k++) begin
            if (k == 0)  bus.sw = 4'b0001;
            if (k == 20) bus.sw = 4'b0000;
            @(posedge clk);
            @(negedge clk);
            got = observe();
            exp = exp_q.pop_front();
            tests_run++;
            if (got !== exp) begin
                failed++;
                $display("FAIL rise_fall_ch0 k=%0d got=%h exp=%h", k, got, exp);
            end
        end
    endtask

    task automatic test_glitch();
        frame_t got, exp;
        push_n(12, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        for (int k = 0; k < 12; k++) begin
            if (k == 0) bus.sw = 4'b0010;
            if (k == 3) bus.sw = 4'b0000;
            @(posedge clk);
            @(negedge clk);
            got = observe();
            exp = exp_q.pop_front();
            tests_run++;
            if (got !== exp) begin
                failed++;
                $display("FAIL glitch_ch1 k=%0d got=%h exp=%h", k, got, exp);
            end
        end
    endtask

    task automatic test_low_glitch();
        frame_t got, exp;
        push_n(6, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        push_n(1, 4'b0100, 4'b0100, 4'b0000, 4'b0000);
        push_n(9, 4'b0100, 4'b0000, 4'b0000, 4'b0000);
        push_n(1, 4'b0100, 4'b0000, 4'b0000, lp(4'b0100));
        push_n(13, 4'b0100, 4'b0000, 4'b0000, 4'b0000);
        push_n(1, 4'b0000, 4'b0000, 4'b0100, 4'b0000);
        push_n(1, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        for (int k = 0; k < 32; k++) begin
            if (k == 0)  bus.sw = 4'b0100;
            if (k == 10) bus.sw = 4'b0000;
            if (k == 12) bus.sw = 4'b0100;
            if (k == 24) bus.sw = 4'b0000;
            @(posedge clk);
            @(negedge clk);
            got = observe();
            exp = exp_q.pop_front();
            tests_run++;
            if (got !== exp) begin
                failed++;
                $display("FAIL low_glitch_ch2 k=%0d got=%h exp=%h", k, got, exp);
            end
        end
    endtask

    task automatic test_simultaneous();
        frame_t got, exp;
        push_n(6, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        push_n(1, 4'b1111, 4'b1111, 4'b0000, 4'b0000);
        push_n(9, 4'b1111, 4'b0000, 4'b0000, 4'b0000);
        push_n(1, 4'b1111, 4'b0000, 4'b0000, lp(4'b1111));
        push_n(9, 4'b1111, 4'b0000, 4'b0000, 4'b0000);
        push_n(1, 4'b0000, 4'b0000, 4'b1111, 4'b0000);
        push_n(1, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        for (int k = 0; k < 28; k++) begin
            if (k == 0)  bus.sw = 4'b1111;
            if (k == 20) bus.sw = 4'b0000;
            @(posedge clk);
            @(negedge clk);
            got = observe();
            exp = exp_q.pop_front();
            tests_run++;
            if (got !== exp) begin
                failed++;
                $display("FAIL simultaneous k=%0d got=%h exp=%h", k, got, exp);
            end
        end
    endtask

    task automatic test_reset_abort();
        frame_t got, exp;
        push_n(12, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        push_n(1, 4'b1000, 4'b1000, 4'b0000, 4'b0000);
        push_n(7, 4'b1000, 4'b0000, 4'b0000, 4'b0000);
        push_n(1, 4'b0000, 4'b0000, 4'b1000, 4'b0000);
        push_n(1, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        for (int k = 0; k < 22; k++) begin
            if (k == 0)  bus.sw = 4'b1000;
            if (k == 4)  reset = 1'b1;
            if (k == 6)  reset = 1'b0;
            if (k == 14) bus.sw = 4'b0000;
            @(posedge clk);
            @(negedge clk);
            got = observe();
            exp = exp_q.pop_front();
            tests_run++;
            if (got !== exp) begin
                failed++;
                $display("FAIL reset_abort_ch3 k=%0d got=%h exp=%h", k, got, exp);
            end
        end
    endtask

    initial begin
        bus.sw = 4'b0000;
        test_reset();
        test_rise_fall();
        test_glitch();
        test_low_glitch();
        test_simultaneous();
        test_reset_abort();
        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end
endmodule
